// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types: register-file word, register address and queued write request.
package wb_arbiter_pkg;
  localparam int CREG_NUM = 32;
  localparam int CREG_AW  = $clog2(CREG_NUM);

  typedef logic [31:0]        word_t;
  typedef logic [CREG_AW-1:0] creg_addr_t;

  typedef struct packed {
    creg_addr_t id;
    word_t      data;
  } wb_req_t;

  typedef enum logic {
    PORT_ALU = 1'b0,
    PORT_MEM = 1'b1
  } port_t;

  function automatic logic [CREG_NUM-1:0] id_onehot(input creg_addr_t id);
    logic [CREG_NUM-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/wb_queue.sv
// Shifting FIFO of writeback requests; entry 0 is always the head, so entry i is valid iff i < count.
module wb_queue
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  wb_req_t          din,
  output wb_req_t          head,
  output creg_addr_t       ids [DEPTH],
  output logic [DEPTH-1:0] valid_vec,
  output logic             full,
  output logic             empty
);
  localparam int CW = $clog2(DEPTH + 1);

  wb_req_t       mem_q [DEPTH];
  wb_req_t       mem_d [DEPTH];
  logic [CW-1:0] count_q;
  int            wr_idx;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    wr_idx = int'(count_q);
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i + 1];
      mem_d[DEPTH-1] = '0;
      wr_idx = wr_idx - 1;
    end
    // a same-edge pop shifts everything down, so the new entry lands one slot lower
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == wr_idx) mem_d[i] = din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ids[i]       = mem_q[i].id;
      valid_vec[i] = (i < int'(count_q));
    end
  end

  assign head  = mem_q[0];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter over ALU/MEM queues driving one registered regfile write per cycle.
// Optional WB_FWD_EN adds two forwarding read ports that observe the write in flight.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  creg_addr_t          alu_id,
  input  word_t               alu_data,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  creg_addr_t          mem_id,
  input  word_t               mem_data,
  output logic                rf_valid,
  output creg_addr_t          rf_id,
  output word_t               rf_data,
  output logic [CREG_NUM-1:0] pending
`ifdef WB_FWD_EN
  ,
  input  creg_addr_t          fwd_ra1,
  input  creg_addr_t          fwd_ra2,
  output logic                fwd_hit1,
  output logic                fwd_hit2,
  output word_t               fwd_data1,
  output word_t               fwd_data2
`endif
);
  wb_req_t          alu_head, mem_head;
  creg_addr_t       alu_ids [DEPTH];
  creg_addr_t       mem_ids [DEPTH];
  logic [DEPTH-1:0] alu_vv, mem_vv;
  logic             alu_full, alu_empty, mem_full, mem_empty;
  logic             alu_push, mem_push, grant_alu, grant_mem;
  port_t            rr_q, rr_d;

  assign alu_ready = !reset && !alu_full;
  assign mem_ready = !reset && !mem_full;
  // id 0 is the hard-wired zero register: accept the handshake but never store it
  assign alu_push  = alu_valid && alu_ready && (alu_id != '0);
  assign mem_push  = mem_valid && mem_ready && (mem_id != '0);

  wb_queue #(.DEPTH(DEPTH)) u_alu_q (
    .clk(clk), .reset(reset), .push(alu_push), .pop(grant_alu),
    .din('{id: alu_id, data: alu_data}), .head(alu_head), .ids(alu_ids),
    .valid_vec(alu_vv), .full(alu_full), .empty(alu_empty)
  );

  wb_queue #(.DEPTH(DEPTH)) u_mem_q (
    .clk(clk), .reset(reset), .push(mem_push), .pop(grant_mem),
    .din('{id: mem_id, data: mem_data}), .head(mem_head), .ids(mem_ids),
    .valid_vec(mem_vv), .full(mem_full), .empty(mem_empty)
  );

  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    rr_d      = rr_q;
    if (!alu_empty && !mem_empty) begin
      if (rr_q == PORT_ALU) begin
        grant_alu = 1'b1;
        rr_d      = PORT_MEM;
      end else begin
        grant_mem = 1'b1;
        rr_d      = PORT_ALU;
      end
    end else if (!alu_empty) begin
      grant_alu = 1'b1;
    end else if (!mem_empty) begin
      grant_mem = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q     <= PORT_ALU;
      rf_valid <= 1'b0;
      rf_id    <= '0;
      rf_data  <= '0;
    end else begin
      rr_q     <= rr_d;
      rf_valid <= grant_alu || grant_mem;
      if (grant_alu) begin
        rf_id   <= alu_head.id;
        rf_data <= alu_head.data;
      end else if (grant_mem) begin
        rf_id   <= mem_head.id;
        rf_data <= mem_head.data;
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_vv[i]) pending = pending | id_onehot(alu_ids[i]);
      if (mem_vv[i]) pending = pending | id_onehot(mem_ids[i]);
    end
    if (rf_valid) pending = pending | id_onehot(rf_id);
    pending[0] = 1'b0;
  end

`ifdef WB_FWD_EN
  assign fwd_hit1  = rf_valid && (rf_id == fwd_ra1) && (fwd_ra1 != '0);
  assign fwd_hit2  = rf_valid && (rf_id == fwd_ra2) && (fwd_ra2 != '0);
  assign fwd_data1 = fwd_hit1 ? rf_data : '0;
  assign fwd_data2 = fwd_hit2 ? rf_data : '0;
`endif
endmodule
